// File: rtl/bist_pkg.sv
// Shared definitions for the self-test arithmetic responders: state encoding,
// default widths and step counts of the root and multiply phases.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROOT = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int A_W_DEF    = 8;
    localparam int B_W_DEF    = 8;
    localparam int Y_W_DEF    = 12;

    localparam int ROOT_STEPS = 3;
    localparam int MUL_STEPS  = 3;

    // Root is 0..6 for an 8-bit radicand; a 3-bit candidate cubed fits 9 bits.
    localparam int ROOT_W     = 3;
    localparam int CNT_W      = 2;
    localparam int CUBE_W     = 9;

endpackage

// File: rtl/cbrt_step.sv
// One bit of the restoring integer cube root: try setting bit i of r and keep
// it if the candidate cubed does not exceed the radicand.
module cbrt_step
    import bist_pkg::*;
#(
    parameter int B_W = B_W_DEF
) (
    input  logic [ROOT_W-1:0] r,
    input  logic [CNT_W-1:0]  i,
    input  logic [B_W-1:0]    b_reg,
    output logic [ROOT_W-1:0] r_next
);

    logic [ROOT_W-1:0] cand;
    logic [CUBE_W-1:0] cand_w;
    logic [CUBE_W-1:0] cube;
    logic [CUBE_W-1:0] b_ext;

    always_comb begin
        cand   = r | (ROOT_W'(1) << i);
        cand_w = CUBE_W'(cand);
        cube   = cand_w * cand_w * cand_w;
        b_ext  = CUBE_W'(b_reg);
        r_next = (cube <= b_ext) ? cand : r;
    end

endmodule

// File: rtl/a_cbrtb.sv
// Multi-cycle responder computing y = a * floor(cbrt(b)) on the start/ready
// handshake. Define A_CBRTB_STICKY_READY_EN to hold y_ready high while idle.
module a_cbrtb
    import bist_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int B_W = B_W_DEF,
    parameter int Y_W = Y_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W-1:0] b_in,
    input  logic           in_ready,
    output logic [Y_W-1:0] y_out,
    output logic           y_ready
);

    localparam int ACC_W = A_W + ROOT_W;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [A_W-1:0]    a_reg, a_next;
    logic [B_W-1:0]    b_reg, b_next;
    logic [ROOT_W-1:0] r_reg, r_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [Y_W-1:0]    y_reg, y_next;
    logic              ready_reg, ready_next;

    logic [ROOT_W-1:0] root_step;
    logic [ACC_W-1:0]  addend;

    cbrt_step #(.B_W(B_W)) u_step (
        .r      (r_reg),
        .i      (cnt_reg),
        .b_reg  (b_reg),
        .r_next (root_step)
    );

    assign addend  = ACC_W'(a_reg) << cnt_reg;
    assign y_out   = y_reg;
    assign y_ready = ready_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            r_reg     <= '0;
            acc_reg   <= '0;
            y_reg     <= '0;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            r_reg     <= r_next;
            acc_reg   <= acc_next;
            y_reg     <= y_next;
            ready_reg <= ready_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        r_next     = r_reg;
        acc_next   = acc_reg;
        y_next     = y_reg;
`ifdef A_CBRTB_STICKY_READY_EN
        ready_next = ready_reg;
`else
        ready_next = 1'b0;
`endif

        case (state_reg)
            IDLE: begin
                if (in_ready) begin
                    a_next     = a_in;
                    b_next     = b_in;
                    r_next     = '0;
                    acc_next   = '0;
                    cnt_next   = CNT_W'(ROOT_STEPS - 1);
                    ready_next = 1'b0;
                    state_next = ROOT;
                end
            end
            ROOT: begin
                // cnt_reg is the bit index i, counting down from the MSB
                r_next = root_step;
                if (cnt_reg == '0) begin
                    state_next = MUL;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            MUL: begin
                // cnt_reg is the bit index j, counting up; the last step also
                // loads the output registers so the result is visible in DONE
                if (r_reg[cnt_reg]) begin
                    acc_next = acc_reg + addend;
                end
                if (cnt_reg == CNT_W'(MUL_STEPS - 1)) begin
                    y_next     = Y_W'(acc_next);
                    ready_next = 1'b1;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/a_cbrtb.md
# a_cbrtb

- Multi-cycle arithmetic responder that computes y = a × ⌊∛b⌋ for unsigned 8-bit a and b.
- Answers the start/ready handshake issued by the self-test controller, and is a drop-in alternative to the existing a × √b unit on that interface.
- Output is 12 bits, so the controller's 12-bit CRC signature loop and its normal-mode output path need no change.
- Supports both functional operation and LFSR-driven self-test.

## Interface

Parameters:
- `A_W`, default 8: width of operand a.
- `B_W`, default 8: width of operand b. Fixed at 8; the root loop depends on it.
- `Y_W`, default 12: result width. Values above 12 are zero-extended.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset. Assertion takes effect immediately; release is synchronous to `clk` at the integration level.
- `a_in`  in  8  multiplicand.
- `b_in`  in  8  radicand.
- `in_ready`  in  1  start strobe. Sampled only in IDLE.
- `y_out`  out  12  result. Holds its value until the next DONE.
- `y_ready`  out  1  result-valid indication.

## Operation

- **Reset values (rst=0):**
  - state = IDLE.
  - `y_out` = 0 and `y_ready` = 0.
  - All internal registers (operand registers, root r, accumulator) = 0.
- **IDLE:**
  - If `in_ready`=1, capture `a_in` and `b_in`, clear r and the accumulator, and go to ROOT with bit index i=2.
  - Otherwise stay in IDLE.
- **ROOT (3 cycles, i = 2, 1, 0):**
  - Form candidate c = r | (1<<i) and compute c³, which is at most 343 (9-bit, combinational).
  - If c³ ≤ b_reg, set r = c.
  - After i=0, go to MUL with j=0.
  - Range of r: 0..6, since ∛255 = 6.34.
- **MUL (3 cycles, j = 0, 1, 2):**
  - Shift-add step: if r[j]=1, acc += a_reg << j.
  - acc is 11 bits; the maximum is 255 × 6 = 1530, so no overflow is possible.
  - After j=2, go to DONE.
- **DONE (1 cycle):**
  - `y_out` ← zero-extended acc and `y_ready` = 1.
  - Then go to IDLE.
- **`in_ready` outside IDLE:** ignored (no queueing), including during DONE.
- **Input changes:** `a_in` and `b_in` may change freely after the capture cycle.
- **Reset mid-computation:** aborts the operation. `y_out` returns to 0; no partial result is ever presented.

## Timing

- Cycle 0: `in_ready`=1 sampled in IDLE.
- Cycles 1–3: ROOT.
- Cycles 4–6: MUL.
- Cycle 7: DONE; `y_out` is valid and `y_ready`=1 (registered outputs).
- Latency is 7 cycles from strobe to ready. Throughput is one result per 8 cycles.
- The earliest next accepted `in_ready` is cycle 8.
- `y_ready` is a one-cycle pulse unless the sticky option below is compiled in.
- The controller must poll `y_ready` every cycle, or use the sticky build.

## Configuration

- Macro: `A_CBRTB_STICKY_READY_EN`.
- **Defined:**
  - `y_ready` rises in DONE and stays high in IDLE.
  - It clears in the cycle after a new `in_ready` is accepted, or on reset.
  - `y_out` stays stable throughout.
- **Undefined:** `y_ready` is high only in the DONE cycle.
- Datapath, latency and `y_out` behaviour are identical in both builds.

## Structure

- Shared package `bist_pkg` holds:
  - the state encoding (IDLE, ROOT, MUL, DONE);
  - the `A_W`/`B_W`/`Y_W` defaults;
  - the constant ROOT_STEPS = 3 and the constant MUL_STEPS = 3.
- One sub-module, `cbrt_step`, is natural.
  - It is combinational.
  - Inputs: r, i, b_reg. Output: next r.
  - It is instantiated once and time-shared over the three ROOT cycles.
- The FSM, operand registers, shift-add accumulator and output registers live in `a_cbrtb`.

## Test plan

- **Basic:** `a_in`=100, `b_in`=27, pulse `in_ready` → `y_ready`=1 exactly 7 cycles later with `y_out`=300 (0x12C).
- **Maximum operands:** a=255, b=255 → `y_out`=1530 (0x5FA). Cube-root boundary: b=216 → root 6; b=215 → root 5, so a=255 gives 1275. Perfect cube b=8 with a=10 → `y_out`=20.
- **Zero cases:** b=0, a=200 → `y_out`=0 with `y_ready` still pulsed. a=0, b=125 → `y_out`=0.
- **Busy rejection:** hold `in_ready` high for 10 cycles with a=3, b=64 → a single result, 12 (0x00C), at cycle 7. The second result is accepted no earlier than cycle 8 and is ready at cycle 15.
- **Reset mid-computation:** drive rst=0 at cycle 4 of a run → `y_out`=0 and `y_ready`=0 immediately. After release, IDLE; a new run gives the correct result.
- **Sticky build** (`A_CBRTB_STICKY_READY_EN` defined): `y_ready` stays 1 for 20 idle cycles after a=7, b=1 (`y_out`=7). It drops in the cycle after the next accepted `in_ready`.
